// File: rtl/instr_stream_loader.sv
// Parses a framed program image (A5, LEN_LO, LEN_HI, 4*N bytes LSB-first) from the UART
// and drives the instruction-load bus. Define LOADER_CHECKSUM_EN for a trailing XOR checksum byte.
module instr_stream_loader #(
  parameter int         MAX_WORDS      = 256,
  parameter logic [7:0] START_BYTE     = 8'hA5,
  parameter int         TIMEOUT_CYCLES = 5000000,
  parameter int         TO_W           = 24
) (
  input  logic        clk,
  input  logic        reset,
  input  logic [7:0]  i_rx_data,
  input  logic        i_rx_valid,
  output logic [31:0] o_ld_instr_data,
  output logic [31:0] o_ld_instr_addr,
  output logic        o_ld_instr_wren,
  output logic        o_ld_instr_active,
  output logic        o_done,
  output logic        o_err,
  output logic [1:0]  o_err_code
);

  localparam int IDX_W = $clog2(MAX_WORDS) + 1;
  localparam logic [TO_W-1:0] TO_LAST = TO_W'(TIMEOUT_CYCLES - 1);

`ifdef LOADER_CHECKSUM_EN
  typedef enum logic [2:0] {
    S_IDLE = 3'd0, S_LEN_LO = 3'd1, S_LEN_HI = 3'd2, S_DATA = 3'd3, S_DONE = 3'd4, S_CSUM = 3'd5
  } state_t;
  localparam state_t S_FINAL = S_CSUM;
`else
  typedef enum logic [2:0] {
    S_IDLE = 3'd0, S_LEN_LO = 3'd1, S_LEN_HI = 3'd2, S_DATA = 3'd3, S_DONE = 3'd4
  } state_t;
  localparam state_t S_FINAL = S_DONE;
`endif

  state_t            state_r, state_nxt_s;
  logic [7:0]        len_lo_r;
  logic [15:0]       len_r;
  logic [1:0]        byte_idx_r;
  logic [23:0]       word_r;
  logic [IDX_W-1:0]  word_idx_r;
  logic [TO_W-1:0]   to_cnt_r;

  logic [15:0] len_s;
  logic        start_s, counting_s, timeout_s, len_bad_s, len_err_s, word_done_s, last_word_s;
  logic        csum_err_s;

  logic [31:0] data_nxt_s, addr_nxt_s;
  logic        wren_nxt_s, active_nxt_s, done_nxt_s, err_nxt_s;
  logic [1:0]  err_code_nxt_s;

`ifdef LOADER_CHECKSUM_EN
  logic [7:0] csum_r;
  logic       csum_ok_s;
  assign csum_ok_s  = (i_rx_data == csum_r);
  assign csum_err_s = (state_r == S_CSUM) && i_rx_valid && !csum_ok_s;
`else
  assign csum_err_s = 1'b0;
`endif

  assign len_s       = {i_rx_data, len_lo_r};
  assign start_s     = (state_r == S_IDLE) && i_rx_valid && (i_rx_data == START_BYTE);
  assign counting_s  = (state_r != S_IDLE) && (state_r != S_DONE);
  assign timeout_s   = counting_s && !i_rx_valid && (to_cnt_r == TO_LAST);
  assign len_bad_s   = ({16'd0, len_s} > MAX_WORDS[31:0]);
  assign len_err_s   = (state_r == S_LEN_HI) && i_rx_valid && len_bad_s;
  assign word_done_s = (state_r == S_DATA) && i_rx_valid && (byte_idx_r == 2'd3);
  assign last_word_s = ((16'(word_idx_r) + 16'd1) == len_r);

  // State register
  always_ff @(posedge clk or posedge reset) begin
    if (reset) state_r <= S_IDLE;
    else       state_r <= state_nxt_s;
  end

  // Next-state decode; a timeout only fires on a cycle without a strobe
  always_comb begin
    state_nxt_s = state_r;
    case (state_r)
      S_IDLE:   if (start_s) state_nxt_s = S_LEN_LO; else state_nxt_s = S_IDLE;
      S_LEN_LO: begin
        if (timeout_s)       state_nxt_s = S_IDLE;
        else if (i_rx_valid) state_nxt_s = S_LEN_HI;
        else                 state_nxt_s = S_LEN_LO;
      end
      S_LEN_HI: begin
        if (timeout_s)                 state_nxt_s = S_IDLE;
        else if (!i_rx_valid)          state_nxt_s = S_LEN_HI;
        else if (len_s == 16'd0)       state_nxt_s = S_FINAL;
        else if (len_bad_s)            state_nxt_s = S_IDLE;
        else                           state_nxt_s = S_DATA;
      end
      S_DATA: begin
        if (timeout_s)                        state_nxt_s = S_IDLE;
        else if (word_done_s && last_word_s)  state_nxt_s = S_FINAL;
        else                                  state_nxt_s = S_DATA;
      end
`ifdef LOADER_CHECKSUM_EN
      S_CSUM: begin
        if (timeout_s)                      state_nxt_s = S_IDLE;
        else if (i_rx_valid && csum_ok_s)   state_nxt_s = S_DONE;
        else if (i_rx_valid)                state_nxt_s = S_IDLE;
        else                                state_nxt_s = S_CSUM;
      end
`endif
      S_DONE:   state_nxt_s = S_IDLE;
      default:  state_nxt_s = S_IDLE;
    endcase
  end

  // Next values of the registered bus and status outputs
  always_comb begin
    data_nxt_s     = o_ld_instr_data;
    addr_nxt_s     = o_ld_instr_addr;
    active_nxt_s   = o_ld_instr_active;
    err_nxt_s      = o_err;
    err_code_nxt_s = o_err_code;
    done_nxt_s     = 1'b0;
    if (word_done_s) begin
      wren_nxt_s = 1'b1;
      data_nxt_s = {i_rx_data, word_r};
      addr_nxt_s = {{(32-IDX_W){1'b0}}, word_idx_r};
    end else begin
      wren_nxt_s = 1'b0;
    end
    if (start_s) begin
      active_nxt_s   = 1'b1;
      err_nxt_s      = 1'b0;
      err_code_nxt_s = 2'b00;
    end else if (timeout_s) begin
      active_nxt_s   = 1'b0;
      err_nxt_s      = 1'b1;
      err_code_nxt_s = 2'b01;
    end else if (len_err_s) begin
      active_nxt_s   = 1'b0;
      err_nxt_s      = 1'b1;
      err_code_nxt_s = 2'b10;
    end else if (csum_err_s) begin
      active_nxt_s   = 1'b0;
      err_nxt_s      = 1'b1;
      err_code_nxt_s = 2'b11;
    end else if (state_r == S_DONE) begin
      active_nxt_s = 1'b0;
      done_nxt_s   = 1'b1;
    end else begin
      active_nxt_s = o_ld_instr_active;
    end
  end

  // Output registers, byte/word assembly and inter-byte timeout counter
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      o_ld_instr_data   <= 32'd0;
      o_ld_instr_addr   <= 32'd0;
      o_ld_instr_wren   <= 1'b0;
      o_ld_instr_active <= 1'b0;
      o_done            <= 1'b0;
      o_err             <= 1'b0;
      o_err_code        <= 2'b00;
      len_lo_r          <= 8'd0;
      len_r             <= 16'd0;
      byte_idx_r        <= 2'd0;
      word_r            <= 24'd0;
      word_idx_r        <= '0;
      to_cnt_r          <= '0;
`ifdef LOADER_CHECKSUM_EN
      csum_r            <= 8'd0;
`endif
    end else begin
      o_ld_instr_data   <= data_nxt_s;
      o_ld_instr_addr   <= addr_nxt_s;
      o_ld_instr_wren   <= wren_nxt_s;
      o_ld_instr_active <= active_nxt_s;
      o_done            <= done_nxt_s;
      o_err             <= err_nxt_s;
      o_err_code        <= err_code_nxt_s;
      if (state_r == S_LEN_LO && i_rx_valid) len_lo_r <= i_rx_data;
      if (state_r == S_LEN_HI && i_rx_valid) len_r    <= len_s;
      if (start_s) begin
        byte_idx_r <= 2'd0;
        word_idx_r <= '0;
`ifdef LOADER_CHECKSUM_EN
        csum_r     <= 8'd0;
`endif
      end else if (state_r == S_DATA && i_rx_valid) begin
        byte_idx_r <= byte_idx_r + 2'd1;
`ifdef LOADER_CHECKSUM_EN
        csum_r     <= csum_r ^ i_rx_data;
`endif
        case (byte_idx_r)
          2'd0:    word_r[7:0]   <= i_rx_data;
          2'd1:    word_r[15:8]  <= i_rx_data;
          2'd2:    word_r[23:16] <= i_rx_data;
          default: word_idx_r    <= word_idx_r + IDX_W'(1);
        endcase
      end
      if (!counting_s || i_rx_valid || timeout_s) to_cnt_r <= '0;
      else                                        to_cnt_r <= to_cnt_r + TO_W'(1);
    end
  end

endmodule

// File: tb/tb_instr_stream_loader.sv
// Scoreboard bench for instr_stream_loader: expected writes are queued as frames are sent
// and popped by a monitor on every wren pulse; per-scenario tasks check framing and errors.
module tb_instr_stream_loader;
  localparam int TO = 100;

  logic        clk = 1'b0;
  logic        reset = 1'b1;
  logic [7:0]  rx_data = 8'h00;
  logic        rx_valid = 1'b0;
  logic [31:0] ld_data, ld_addr;
  logic        ld_wren, ld_active, done, err;
  logic [1:0]  err_code;

  int checks = 0;
  int errors = 0;
  int wr_cnt = 0;
  int done_cnt = 0;
  logic [63:0] sb_q[$];
  logic [63:0] exp_wr;
  logic [7:0]  xor_acc;

  instr_stream_loader #(
    .MAX_WORDS(256), .START_BYTE(8'hA5), .TIMEOUT_CYCLES(TO), .TO_W(24)
  ) dut (
    .clk(clk), .reset(reset), .i_rx_data(rx_data), .i_rx_valid(rx_valid),
    .o_ld_instr_data(ld_data), .o_ld_instr_addr(ld_addr), .o_ld_instr_wren(ld_wren),
    .o_ld_instr_active(ld_active), .o_done(done), .o_err(err), .o_err_code(err_code)
  );

  always #5 clk = ~clk;

  // Scoreboard monitor: samples just after each rising edge
  always @(posedge clk) begin
    #1;
    if (ld_wren === 1'b1) begin
      wr_cnt++;
      checks++;
      if (sb_q.size() == 0) begin
        errors++;
        $display("FAIL wr_unexpected: got addr %0d data %h, expected no write", ld_addr, ld_data);
      end else begin
        exp_wr = sb_q.pop_front();
        if ({ld_addr, ld_data} !== exp_wr) begin
          errors++;
          $display("FAIL wr_word: got addr %0d data %h, expected addr %0d data %h",
                   ld_addr, ld_data, exp_wr[63:32], exp_wr[31:0]);
        end
      end
    end
    if (done === 1'b1) done_cnt++;
  end

  initial begin
    #1000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  task automatic send_byte(input logic [7:0] b);
    rx_data  = b;
    rx_valid = 1'b1;
    @(negedge clk);
    rx_valid = 1'b0;
  endtask

  task automatic send_start();
    xor_acc = 8'h00;
    send_byte(8'hA5);
  endtask

  task automatic send_data(input logic [7:0] b);
    xor_acc = xor_acc ^ b;
    send_byte(b);
  endtask

  task automatic send_word(input logic [31:0] w);
    for (int i = 0; i < 4; i++) send_data(w[8*i +: 8]);
  endtask

  task automatic send_end();
`ifdef LOADER_CHECKSUM_EN
    send_byte(xor_acc);
`endif
  endtask

  task automatic check_counts(input string name, input int wr0, input int exp_wr_n,
                              input int d0, input int exp_done_n);
    checks++;
    if (wr_cnt - wr0 !== exp_wr_n || done_cnt - d0 !== exp_done_n || sb_q.size() != 0) begin
      errors++;
      $display("FAIL %s_counts: got writes %0d dones %0d pending %0d, expected writes %0d dones %0d pending 0",
               name, wr_cnt - wr0, done_cnt - d0, sb_q.size(), exp_wr_n, exp_done_n);
    end
  endtask

  task automatic test_reset();
    reset = 1'b1;
    repeat (2) @(negedge clk);
    checks++;
    if ({ld_data, ld_addr} !== 64'd0) begin
      errors++;
      $display("FAIL reset_bus: got data %h addr %h, expected 0", ld_data, ld_addr);
    end
    checks++;
    if ({ld_wren, ld_active, done, err, err_code} !== 6'd0) begin
      errors++;
      $display("FAIL reset_flags: got %b, expected 000000", {ld_wren, ld_active, done, err, err_code});
    end
    reset = 1'b0;
    repeat (2) @(negedge clk);
    checks++;
    if ({ld_wren, ld_active, done, err, err_code} !== 6'd0) begin
      errors++;
      $display("FAIL post_reset_flags: got %b, expected 000000", {ld_wren, ld_active, done, err, err_code});
    end
  endtask

  task automatic test_two_words();
    int wr0 = wr_cnt;
    int d0 = done_cnt;
    sb_q.push_back({32'd0, 32'h0000_0013});
    sb_q.push_back({32'd1, 32'h0010_0093});
    send_start(); send_byte(8'h02); send_byte(8'h00);
    send_word(32'h0000_0013); send_word(32'h0010_0093); send_end();
`ifndef LOADER_CHECKSUM_EN
    checks++;
    if (ld_wren !== 1'b1) begin
      errors++;
      $display("FAIL two_last_wren: got %b, expected 1", ld_wren);
    end
`endif
    checks++;
    if ({ld_active, done} !== 2'b10) begin
      errors++;
      $display("FAIL two_pre_done: got active/done %b, expected 10", {ld_active, done});
    end
    @(negedge clk);
    checks++;
    if ({ld_active, done, err} !== 3'b010) begin
      errors++;
      $display("FAIL two_done: got active/done/err %b, expected 010", {ld_active, done, err});
    end
    @(negedge clk);
    checks++;
    if (done !== 1'b0) begin
      errors++;
      $display("FAIL two_done_pulse: got done %b, expected 0", done);
    end
    check_counts("two", wr0, 2, d0, 1);
  endtask

  task automatic test_zero_len();
    int wr0 = wr_cnt;
    int d0 = done_cnt;
    send_start(); send_byte(8'h00); send_byte(8'h00); send_end();
    checks++;
    if ({ld_active, done} !== 2'b10) begin
      errors++;
      $display("FAIL zero_pre_done: got active/done %b, expected 10", {ld_active, done});
    end
    @(negedge clk);
    checks++;
    if ({ld_active, done} !== 2'b01) begin
      errors++;
      $display("FAIL zero_done: got active/done %b, expected 01", {ld_active, done});
    end
    repeat (2) @(negedge clk);
    check_counts("zero", wr0, 0, d0, 1);
  endtask

  task automatic test_len_err();
    int wr0 = wr_cnt;
    int d0 = done_cnt;
    send_start(); send_byte(8'h01); send_byte(8'h01);
    checks++;
    if ({ld_active, err, err_code} !== 4'b0110) begin
      errors++;
      $display("FAIL len_err: got active/err/code %b, expected 0110", {ld_active, err, err_code});
    end
    repeat (5) @(negedge clk);
    checks++;
    if ({err, err_code} !== 3'b110) begin
      errors++;
      $display("FAIL len_err_sticky: got err/code %b, expected 110", {err, err_code});
    end
    send_start();
    checks++;
    if ({ld_active, err, err_code} !== 4'b1000) begin
      errors++;
      $display("FAIL len_err_clear: got active/err/code %b, expected 1000", {ld_active, err, err_code});
    end
    send_byte(8'h00); send_byte(8'h00); send_end();
    repeat (3) @(negedge clk);
    check_counts("len_err", wr0, 0, d0, 1);
  endtask

  task automatic test_timeout();
    int wr0 = wr_cnt;
    int d0 = done_cnt;
    send_start(); send_byte(8'h01); send_byte(8'h00); send_data(8'h11); send_data(8'h22);
    repeat (TO - 1) @(negedge clk);
    checks++;
    if ({ld_active, err} !== 2'b10) begin
      errors++;
      $display("FAIL timeout_early: got active/err %b at cycle %0d, expected 10", {ld_active, err}, TO - 1);
    end
    @(negedge clk);
    checks++;
    if ({ld_active, err, err_code} !== 4'b0101) begin
      errors++;
      $display("FAIL timeout: got active/err/code %b, expected 0101", {ld_active, err, err_code});
    end
    check_counts("timeout", wr0, 0, d0, 0);
  endtask

  task automatic test_reset_mid_frame();
    int wr0;
    int d0;
    send_start(); send_byte(8'h04); send_byte(8'h00); send_data(8'hAA);
    #2 reset = 1'b1;
    #1;
    checks++;
    if ({ld_data, ld_addr, ld_wren, ld_active, done, err, err_code} !== 70'd0) begin
      errors++;
      $display("FAIL async_reset: got active %b data %h addr %h, expected all 0", ld_active, ld_data, ld_addr);
    end
    @(negedge clk);
    reset = 1'b0;
    wr0 = wr_cnt;
    d0 = done_cnt;
    sb_q.push_back({32'd0, 32'hDEAD_BEEF});
    send_start(); send_byte(8'h01); send_byte(8'h00); send_word(32'hDEAD_BEEF); send_end();
    repeat (3) @(negedge clk);
    check_counts("after_reset", wr0, 1, d0, 1);
  endtask

  task automatic test_back_to_back();
    int wr0 = wr_cnt;
    int d0 = done_cnt;
    sb_q.push_back({32'd0, 32'hA500_A5A5});
    sb_q.push_back({32'd0, 32'h1234_5678});
    send_start(); send_byte(8'h01); send_byte(8'h00); send_word(32'hA500_A5A5); send_end();
    send_byte(8'hA5);
    checks++;
    if ({ld_active, done} !== 2'b01) begin
      errors++;
      $display("FAIL b2b_done_ignores_byte: got active/done %b, expected 01", {ld_active, done});
    end
    send_start(); send_byte(8'h01); send_byte(8'h00); send_word(32'h1234_5678); send_end();
    repeat (3) @(negedge clk);
    check_counts("b2b", wr0, 2, d0, 2);
  endtask

  task automatic test_max_len();
    int wr0 = wr_cnt;
    int d0 = done_cnt;
    logic [31:0] w;
    send_start(); send_byte(8'h00); send_byte(8'h01);
    for (int i = 0; i < 256; i++) begin
      w = {8'(i), 8'(~i), 8'h5A, 8'(i * 3)};
      sb_q.push_back({32'(i), w});
      send_word(w);
    end
    send_end();
    repeat (3) @(negedge clk);
    check_counts("max_len", wr0, 256, d0, 1);
    checks++;
    if ({ld_addr, err} !== {32'd255, 1'b0}) begin
      errors++;
      $display("FAIL max_len_last: got addr %0d err %b, expected addr 255 err 0", ld_addr, err);
    end
  endtask

`ifdef LOADER_CHECKSUM_EN
  task automatic test_checksum();
    int wr0 = wr_cnt;
    int d0 = done_cnt;
    sb_q.push_back({32'd0, 32'h0804_0201});
    send_start(); send_byte(8'h01); send_byte(8'h00); send_word(32'h0804_0201); send_byte(8'h0F);
    repeat (3) @(negedge clk);
    check_counts("csum_ok", wr0, 1, d0, 1);
    wr0 = wr_cnt;
    d0 = done_cnt;
    sb_q.push_back({32'd0, 32'h0804_0201});
    send_start(); send_byte(8'h01); send_byte(8'h00); send_word(32'h0804_0201); send_byte(8'h0E);
    checks++;
    if ({ld_active, err, err_code} !== 4'b0111) begin
      errors++;
      $display("FAIL csum_bad: got active/err/code %b, expected 0111", {ld_active, err, err_code});
    end
    repeat (3) @(negedge clk);
    check_counts("csum_bad", wr0, 1, d0, 0);
  endtask
`endif

  initial begin
    test_reset();
    test_two_words();
    test_zero_len();
    test_len_err();
    test_timeout();
    test_reset_mid_frame();
    test_back_to_back();
    test_max_len();
`ifdef LOADER_CHECKSUM_EN
    test_checksum();
`endif
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/instr_stream_loader.md
Name: instr_stream_loader

Overview:
- Upstream feeder of the memory mapper's instruction-load bus.
- Takes a byte stream from the UART receiver, parses a framed program image and assembles little-endian 32-bit words.
- Drives ld_instr data/addr/wren/active so the mapper stalls the core, rewrites instruction memory, then issues its reset pulse.

Parameters:
- MAX_WORDS, 256, instruction memory depth in words; frames with a longer length are rejected.
- START_BYTE, 8'hA5, frame start marker.
- TIMEOUT_CYCLES, 5000000, idle cycles allowed between bytes inside a frame before abort; minimum 2.
- TO_W, 24, width of the timeout counter; must hold TIMEOUT_CYCLES.

Ports:
- clk  in  1  system clock
- reset  in  1  asynchronous, active-high reset
- i_rx_data  in  8  received byte, valid when i_rx_valid=1
- i_rx_valid  in  1  single-cycle strobe per received byte
- o_ld_instr_data  out  32  assembled instruction word
- o_ld_instr_addr  out  32  word address, 0-based, zero-extended
- o_ld_instr_wren  out  1  one-cycle write pulse per word
- o_ld_instr_active  out  1  high while a frame is being loaded
- o_done  out  1  one-cycle pulse on successful frame completion
- o_err  out  1  sticky error flag; cleared when the next START_BYTE is accepted
- o_err_code  out  2  01=timeout, 10=length>MAX_WORDS, 11=checksum (feature only), 00=none

Behaviour:
- Reset (async): all outputs 0, state IDLE, byte/word counters 0, timeout counter 0.
- Frame format: START_BYTE, LEN_LO, LEN_HI (16-bit word count N), then 4*N data bytes. Each word arrives least-significant byte first.
- States: IDLE, LEN_LO, LEN_HI, DATA, DONE (plus CSUM with the optional feature).
- IDLE: a valid byte equal to START_BYTE moves to LEN_LO. It also clears o_err and o_err_code and sets o_ld_instr_active on the next edge. Other bytes are ignored.
- LEN_LO -> LEN_HI on a valid byte. LEN_HI on a valid byte:
  - N=0: go to DONE.
  - N>MAX_WORDS: set o_err with code 10, go to IDLE, drop active.
  - Otherwise: go to DATA.
- DATA: 2-bit byte index shifts bytes into the word register. On the 4th byte, the next edge sets o_ld_instr_data = word, o_ld_instr_addr = word index, and o_ld_instr_wren=1 for exactly one cycle.
  - Data and addr hold until the next write.
  - Word index increments after each write.
  - After word N-1 is written, go to DONE (CSUM if the feature is compiled in).
- DONE (one cycle): o_ld_instr_active=0 and o_done=1 for one cycle, then IDLE.
  - Active therefore falls exactly one cycle after the last wren pulse.
  - For N=0, active falls immediately after LEN_HI.
- Timeout:
  - In any state except IDLE/DONE, the counter increments each cycle without i_rx_valid and clears on i_rx_valid.
  - At TIMEOUT_CYCLES: o_err=1, code 01, drop active, go to IDLE. Words already written stay in memory.
- Valid bytes in DONE are ignored. No back-pressure exists; every strobe is consumed within its cycle.
- START_BYTE value inside LEN/DATA is treated as data, never as a restart.
- Reset mid-frame: returns to IDLE immediately; active drops asynchronously.
- Address width rule: the word index is $clog2(MAX_WORDS)+1 bits, zero-extended to 32.

Optional Feature:
- Macro LOADER_CHECKSUM_EN.
- Defined:
  - Frame carries one trailing byte equal to the XOR of all 4*N data bytes. The XOR accumulator is cleared on START_BYTE.
  - After the last word the FSM enters CSUM and waits for that byte (timeout applies).
  - Match: go to DONE.
  - Mismatch: o_err=1, code 11, active drops, no o_done pulse. Words are already written; the system integrator decides whether to hold the core.
  - N=0 frames also carry a checksum byte, value 00.
- Undefined: no CSUM state, no accumulator; code 11 never produced.

Test Plan:
- Send A5 02 00 | 13 00 00 00 | 93 00 10 00 -> wren pulses with (addr 0, data 0x00000013) then (addr 1, data 0x00100093); active falls one cycle after 2nd pulse; o_done pulse; o_err=0.
- Send A5 00 00 -> no wren; active high for two bytes' duration then low; o_done=1 one cycle.
- Send A5 01 01 (N=257, MAX_WORDS=256) -> no wren; o_err=1, code 10; active low; following A5 clears o_err.
- Send A5 01 00 11 22, then silence TIMEOUT_CYCLES (use a test override, e.g. TIMEOUT_CYCLES=100) -> o_err=1, code 01, active low at cycle 100 after last byte, no wren.
- Assert reset mid-DATA after A5 04 00 AA -> all outputs 0 immediately; a fresh frame A5 01 00 EF BE AD DE then writes addr 0, data 0xDEADBEEF.
- With LOADER_CHECKSUM_EN, send A5 01 00 01 02 04 08 0F -> o_done; repeat with last byte 0E -> o_err code 11, no o_done.
